// File: rtl/fdd_track_loader.sv
// Multi-drive floppy track cache: moves whole tracks between per-drive track buffers and SD sectors.
// Build option FDD_WRITEBACK_EN adds write-back of a dirty resident track before a new one is loaded.
module fdd_track_loader #(
    parameter int NUM_DRIVES     = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_W        = 6
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [NUM_DRIVES*TRACK_W-1:0]      track,
    input  logic [NUM_DRIVES-1:0]              img_mounted,
    input  logic [NUM_DRIVES-1:0]              img_size_nz,
    input  logic [NUM_DRIVES-1:0]              track_dirty,
    output logic [NUM_DRIVES*32-1:0]           sd_lba,
    output logic [NUM_DRIVES-1:0]              sd_rd,
    output logic [NUM_DRIVES-1:0]              sd_wr,
    input  logic [NUM_DRIVES-1:0]              sd_ack,
    output logic [$clog2(NUM_DRIVES):0]        buf_drive,
    output logic [$clog2(SECS_PER_TRACK)-1:0]  buf_sec,
    output logic                               cpu_wait,
    output logic                               busy
);
    localparam int DRV_W = $clog2(NUM_DRIVES) + 1;
    localparam int SEC_W = $clog2(SECS_PER_TRACK);
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_XFER = 3'd2;
`ifdef FDD_WRITEBACK_EN
    localparam logic [2:0] S_WB_REQ  = 3'd3;
    localparam logic [2:0] S_WB_XFER = 3'd4;
`endif

    logic [2:0]              state_q, state_d;
    logic [NUM_DRIVES-1:0]   present_q, present_d, loaded_q, loaded_d, remount_q, remount_d;
    logic [TRACK_W-1:0]      cur_track_q [NUM_DRIVES];
    logic [TRACK_W-1:0]      cur_track_d [NUM_DRIVES];
    logic [31:0]             lba_q [NUM_DRIVES];
    logic [31:0]             lba_d [NUM_DRIVES];
    logic [TRACK_W-1:0]      new_q, new_d;
    logic [NUM_DRIVES-1:0]   act_q, act_d;
    logic [DRV_W-1:0]        drv_q, drv_d;
    logic [SEC_W-1:0]        sec_q, sec_d;
    logic [NUM_DRIVES-1:0]   rd_q, rd_d, ack_q;
`ifdef FDD_WRITEBACK_EN
    logic [NUM_DRIVES-1:0]   dirty_q, dirty_d, wr_q, wr_d;
    logic [TRACK_W-1:0]      sel_cur;
`else
    logic                    unused_dirty;
    assign unused_dirty = ^track_dirty;
`endif

    logic                    found, lba_set, ack_rise, ack_fall;
    logic [NUM_DRIVES-1:0]   sel_oh, lba_oh;
    logic [TRACK_W-1:0]      sel_trk;
    logic [DRV_W-1:0]        sel_drv;
    logic [31:0]             lba_val, lba_cur;

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t);
        return 32'(SECS_PER_TRACK) * 32'(t);
    endfunction

    always_comb begin
        state_d     = state_q;
        present_d   = present_q;
        loaded_d    = loaded_q;
        remount_d   = remount_q;
        cur_track_d = cur_track_q;
        lba_d       = lba_q;
        new_d       = new_q;
        act_d       = act_q;
        drv_d       = drv_q;
        sec_d       = sec_q;
        rd_d        = rd_q;
`ifdef FDD_WRITEBACK_EN
        dirty_d     = dirty_q;
        wr_d        = wr_q;
        sel_cur     = '0;
`endif
        found   = 1'b0;
        sel_oh  = '0;
        sel_trk = '0;
        sel_drv = '0;
        lba_cur = '0;
        // Descending scan so the lowest-index triggered drive is the one left selected.
        for (int d = NUM_DRIVES - 1; d >= 0; d--) begin
            if (act_q[d]) lba_cur = lba_q[d];
            if (present_q[d] && (remount_q[d] || !loaded_q[d] ||
                                 track[d*TRACK_W +: TRACK_W] != cur_track_q[d])) begin
                found   = 1'b1;
                sel_oh  = '0;
                sel_oh[d] = 1'b1;
                sel_trk = track[d*TRACK_W +: TRACK_W];
                sel_drv = DRV_W'(d);
`ifdef FDD_WRITEBACK_EN
                sel_cur = cur_track_q[d];
`endif
            end
        end

        ack_rise = |(sd_ack & ~ack_q & act_q);
        ack_fall = |(~sd_ack & ack_q & act_q);
        lba_set  = 1'b0;
        lba_val  = '0;
        lba_oh   = act_q;

        case (state_q)
            S_IDLE: if (found) begin
                act_d     = sel_oh;
                drv_d     = sel_drv;
                sec_d     = '0;
                new_d     = sel_trk;
                remount_d = remount_q & ~sel_oh;
                lba_oh    = sel_oh;
                lba_set   = 1'b1;
`ifdef FDD_WRITEBACK_EN
                if (|(sel_oh & dirty_q & loaded_q & ~remount_q)) begin
                    state_d = S_WB_REQ;
                    wr_d    = sel_oh;
                    lba_val = lba_of(sel_cur);
                end else begin
                    state_d = S_RD_REQ;
                    rd_d    = sel_oh;
                    lba_val = lba_of(sel_trk);
                end
`else
                state_d = S_RD_REQ;
                rd_d    = sel_oh;
                lba_val = lba_of(sel_trk);
`endif
            end
`ifdef FDD_WRITEBACK_EN
            S_WB_REQ: if (ack_rise) begin
                wr_d    = '0;
                state_d = S_WB_XFER;
            end
            S_WB_XFER: if (ack_fall) begin
                lba_set = 1'b1;
                if (sec_q == LAST_SEC) begin
                    sec_d   = '0;
                    lba_val = lba_of(new_q);
                    rd_d    = act_q;
                    state_d = S_RD_REQ;
                end else begin
                    sec_d   = sec_q + 1'b1;
                    lba_val = lba_cur + 32'd1;
                    wr_d    = act_q;
                    state_d = S_WB_REQ;
                end
            end
`endif
            S_RD_REQ: if (ack_rise) begin
                rd_d    = '0;
                state_d = S_RD_XFER;
            end
            S_RD_XFER: if (ack_fall) begin
                if (sec_q == LAST_SEC) begin
                    state_d  = S_IDLE;
                    loaded_d = loaded_q | act_q;
`ifdef FDD_WRITEBACK_EN
                    dirty_d  = dirty_q & ~act_q;
`endif
                    for (int d = 0; d < NUM_DRIVES; d++)
                        if (act_q[d]) cur_track_d[d] = new_q;
                end else begin
                    sec_d   = sec_q + 1'b1;
                    lba_set = 1'b1;
                    lba_val = lba_cur + 32'd1;
                    rd_d    = act_q;
                    state_d = S_RD_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host events are applied last so a mount always wins over the FSM's own updates.
        for (int d = 0; d < NUM_DRIVES; d++) begin
            if (lba_set && lba_oh[d]) lba_d[d] = lba_val;
`ifdef FDD_WRITEBACK_EN
            if (track_dirty[d] && !(state_q != S_IDLE && act_q[d])) dirty_d[d] = 1'b1;
`endif
            if (img_mounted[d]) begin
                present_d[d] = img_size_nz[d];
                remount_d[d] = 1'b1;
`ifdef FDD_WRITEBACK_EN
                dirty_d[d]   = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            present_q <= '0;
            loaded_q  <= '0;
            remount_q <= '0;
            new_q     <= '0;
            act_q     <= '0;
            drv_q     <= '0;
            sec_q     <= '0;
            rd_q      <= '0;
            ack_q     <= '0;
`ifdef FDD_WRITEBACK_EN
            dirty_q   <= '0;
            wr_q      <= '0;
`endif
            for (int d = 0; d < NUM_DRIVES; d++) begin
                cur_track_q[d] <= '0;
                lba_q[d]       <= '0;
            end
        end else begin
            state_q     <= state_d;
            present_q   <= present_d;
            loaded_q    <= loaded_d;
            remount_q   <= remount_d;
            cur_track_q <= cur_track_d;
            lba_q       <= lba_d;
            new_q       <= new_d;
            act_q       <= act_d;
            drv_q       <= drv_d;
            sec_q       <= sec_d;
            rd_q        <= rd_d;
            ack_q       <= sd_ack;
`ifdef FDD_WRITEBACK_EN
            dirty_q     <= dirty_d;
            wr_q        <= wr_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_lba
        assign sd_lba[g*32 +: 32] = lba_q[g];
    end

    assign sd_rd     = rd_q;
`ifdef FDD_WRITEBACK_EN
    assign sd_wr     = wr_q;
`else
    assign sd_wr     = '0;
`endif
    assign buf_drive = drv_q;
    assign buf_sec   = sec_q;
    assign busy      = (state_q != S_IDLE);
    assign cpu_wait  = busy;

endmodule

// File: tb/tb_fdd_track_loader.sv
// Scoreboard bench for fdd_track_loader: a track-level model predicts every SD sector request,
// a monitor pops and compares them as the DUT raises sd_rd/sd_wr, and an hps_io responder acks.
module tb_fdd_track_loader;
    localparam int ND  = 2;
    localparam int SPT = 13;
    localparam int TW  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [ND*TW-1:0]  track;
    logic [ND-1:0]     mnt, nz, tdirty, rd, wr, ack;
    logic [ND*32-1:0]  lba;
    logic [1:0]        bdrv;
    logic [3:0]        bsec;
    logic              cpu_wait, busy;

    fdd_track_loader #(.NUM_DRIVES(ND), .SECS_PER_TRACK(SPT), .TRACK_W(TW)) dut (
        .clk_sys(clk), .reset(rst), .track(track), .img_mounted(mnt), .img_size_nz(nz),
        .track_dirty(tdirty), .sd_lba(lba), .sd_rd(rd), .sd_wr(wr), .sd_ack(ack),
        .buf_drive(bdrv), .buf_sec(bsec), .cpu_wait(cpu_wait), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [7:0]  drv;
        logic [31:0] lba;
        logic [7:0]  sec;
    } xfer_t;

    xfer_t sb[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    // Track-level model of each drive.
    bit m_present[ND], m_loaded[ND], m_dirty[ND], m_remount[ND];
    int m_cur[ND], m_track[ND];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < ND; d++) begin
            m_present[d] = 0; m_loaded[d] = 0; m_dirty[d] = 0; m_remount[d] = 0; m_cur[d] = 0;
        end
    endfunction

    // Serve every pending track swap, lowest drive first, pushing its expected sector requests.
    function automatic void settle();
        int a;
        for (int it = 0; it < 4 * ND; it++) begin
            a = -1;
            for (int d = ND - 1; d >= 0; d--)
                if (m_present[d] && (m_remount[d] || !m_loaded[d] || m_track[d] != m_cur[d])) a = d;
            if (a < 0) break;
`ifdef FDD_WRITEBACK_EN
            if (m_dirty[a] && m_loaded[a] && !m_remount[a])
                for (int s = 0; s < SPT; s++)
                    sb.push_back('{1'b1, 8'(a), 32'(SPT * m_cur[a] + s), 8'(s)});
`endif
            for (int s = 0; s < SPT; s++)
                sb.push_back('{1'b0, 8'(a), 32'(SPT * m_track[a] + s), 8'(s)});
            m_cur[a] = m_track[a]; m_loaded[a] = 1; m_dirty[a] = 0; m_remount[a] = 0;
        end
    endfunction

    // Cycle A: dirty/mount strobes; cycle B: new head positions from m_track.
    task automatic apply(input logic [ND-1:0] dmask, input logic [ND-1:0] mmask, input logic [ND-1:0] nzv);
        for (int d = 0; d < ND; d++) begin
            if (dmask[d]) m_dirty[d] = 1;
            if (mmask[d]) begin m_present[d] = nzv[d]; m_remount[d] = 1; m_dirty[d] = 0; end
        end
        settle();
        @(negedge clk);
        tdirty = dmask; mnt = mmask; nz = nzv;
        @(negedge clk);
        tdirty = '0; mnt = '0;
        for (int d = 0; d < ND; d++) track[d*TW +: TW] = TW'(m_track[d]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 6000 && (sb.size() != 0 || busy || ack != '0)) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check({name, "_idle"}, 64'({busy, cpu_wait, 32'(sb.size())}), 64'd0);
    endtask

    task automatic wait_sec(input int s);
        int n = 0;
        while (n < 3000 && !(busy && rd[0] && bsec == 4'(s))) begin @(negedge clk); n++; end
        check("reach_sec", 64'({busy, rd[0], bsec}), 64'({1'b1, 1'b1, 4'(s)}));
    endtask

    // Monitor: every new sector request is compared with the scoreboard head.
    initial begin
        logic [ND-1:0] prev_req;
        xfer_t         e;
        prev_req = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if ((rd[d] | wr[d]) && !prev_req[d]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_req", 64'({8'(d), lba[d*32 +: 32]}), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("xfer", 64'({cpu_wait, wr[d], 8'(d), 8'(bdrv), lba[d*32 +: 32], 8'(bsec)}),
                              64'({1'b1, e.wr, e.drv, e.drv, e.lba, e.sec}));
                    end
                end
                prev_req[d] = rd[d] | wr[d];
            end
        end
    end

    // hps_io responder: random ack latency and width, ack held until the request drops.
    initial begin
        int d_sel, n;
        ack = '0;
        forever begin
            @(negedge clk);
            d_sel = -1;
            for (int d = 0; d < ND; d++) if (rd[d] | wr[d]) d_sel = d;
            if (d_sel >= 0) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ack[d_sel] = 1'b1;
                n = 0;
                while ((rd[d_sel] | wr[d_sel]) && n < 50) begin @(negedge clk); n++; end
                repeat ($urandom_range(1, 3)) @(negedge clk);
                ack[d_sel] = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] dm, mm, nzv;
        rst = 1'b1; track = '0; mnt = '0; nz = '0; tdirty = '0;
        model_reset();
        for (int d = 0; d < ND; d++) m_track[d] = 0;
        repeat (3) @(negedge clk);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_wr", 64'(wr), 64'd0);
        check("rst_wait_busy", 64'({cpu_wait, busy}), 64'd0);
        check("rst_buf", 64'({bdrv, bsec}), 64'd0);
        check("rst_lba", 64'(lba), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        m_track[0] = 0; apply('0, 2'b01, 2'b01); wait_idle("mount_d0");
        m_track[0] = 3; apply('0, '0, '0);        wait_idle("trk3");
        m_track[0] = 4; apply('0, '0, '0);        wait_idle("trk4");
        m_track[0] = 3; apply('0, '0, '0);        wait_idle("back3");
        m_track[0] = 5; apply(2'b01, '0, '0);     wait_idle("dirty_move5");

        m_track[1] = 0; apply('0, 2'b10, 2'b10);  wait_idle("mount_d1");
        m_track[0] = 1; m_track[1] = 2; apply('0, '0, '0); wait_idle("both");
        check("hold_lba_d0", 64'(lba[31:0]), 64'd25);
        check("hold_lba_d1", 64'(lba[63:32]), 64'd38);

        // Unmount d1 and move its head while d0 is loading; dirty strobe on active d0 is dropped.
        m_track[0] = 7; apply('0, '0, '0);
        wait_sec(3);
        mnt = 2'b10; nz = 2'b00; tdirty = 2'b01; track[TW +: TW] = 6'd9;
        @(negedge clk);
        mnt = '0; tdirty = '0;
        m_present[1] = 0; m_remount[1] = 1; m_dirty[1] = 0; m_track[1] = 9;
        settle();
        wait_idle("unmount_d1");
        m_track[0] = 8; apply('0, '0, '0);        wait_idle("after_drop");

        // Re-mount of the active drive mid-op reloads the same track afterwards.
        m_track[0] = 10; apply('0, '0, '0);
        wait_sec(5);
        mnt = 2'b01; nz = 2'b01;
        @(negedge clk);
        mnt = '0;
        m_present[0] = 1; m_remount[0] = 1; m_dirty[0] = 0;
        settle();
        wait_idle("remount_active");

        // Reset in the middle of sector 6, then reload from the track base.
        m_track[0] = 20; apply('0, '0, '0);
        wait_sec(6);
        rst = 1'b1;
        #1;
        check("rst_abort", 64'({rd, wr, cpu_wait, busy}), 64'd0);
        sb.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle("post_rst_quiet");
        apply('0, 2'b01, 2'b01);                  wait_idle("reload_d0");
        apply('0, 2'b10, 2'b10);                  wait_idle("reload_d1");

        for (int it = 0; it < 8; it++) begin
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 1) == 1) m_track[d] = int'($urandom_range(0, 63));
            dm  = ND'($urandom);
            mm  = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
            nzv = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '1;
            apply(dm, mm, nzv);
            wait_idle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
